operand_issue: RTL and testbench
================================

# operand_issue

Decode/issue stage that produces the ALU's operand and opcode bus: splits a 32-bit MIPS instruction, reads the register file, sign-extends immediates, resolves beq, and drives the registered ID/EX outputs (in1, in2, opcode, funccode) consumed by the EX-stage ALU. It sits between the instruction fetch register and the ALU. It owns the ID/EX pipeline register and all RAW-hazard interlock and forwarding decisions for the five supported instructions: add, addi, beq, lw and sw.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register addresses.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- instr_valid / instr_ready  in / out  1 / 1  fetch handshake; an instruction is accepted when both are high
- instr, pc  in  32 / 32  instruction word and its address
- rs_addr, rt_addr  out  5 / 5  register-file read addresses (instr[25:21], instr[20:16]), combinational
- rs_data, rt_data  in  32 / 32  register-file read data, same cycle; the register file is write-before-read
- alu_out  in  32  current EX-stage ALU result, used for forwarding
- mem_wb_reg_write, mem_wb_dest, mem_wb_data  in  1 / 5 / 32  MEM-stage result, used for forwarding
- out_ready  in  1  back end can advance; low freezes the ID/EX register
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_in1, ex_in2  out  32 / 32  ALU operands
- ex_opcode, ex_funccode  out  6 / 6  passed to the ALU
- ex_dest, ex_reg_write, ex_mem_read, ex_mem_write  out  5 / 1 / 1 / 1  downstream control
- ex_store_data  out  32  rt value for sw
- branch_taken, branch_target  out  1 / 32  one-cycle pulse and target for fetch redirect
- illegal  out  1  one-cycle pulse on acceptance of an unsupported encoding

## Operation
- Decode rules:
  - add: opcode 000000 with funct 100000. in1=rs, in2=rt, dest=rd, reg_write=1.
  - Any other funct under opcode 000000 is illegal.
  - addi (001000): in1=rs, in2=sext(imm16), dest=rt, reg_write=1.
  - lw (100011): as addi, plus mem_read=1.
  - sw (101011): in1=rs, in2=sext(imm16), store_data=rt, mem_write=1, reg_write=0.
  - beq (000100): compare the forwarded rs and rt in this stage. If equal, branch_taken=1 and branch_target=pc+4+(sext(imm16)<<2), 32-bit wrap.
  - beq issues to EX with reg_write=0.
- Illegal encodings: pulse illegal and load a bubble (ex_valid=0, all controls 0).
- Any write to register 0 forces reg_write=0 and dest=0. Reads of r0 always return 0, with no forwarding and no hazard on r0.
- Operand selection with FWD_EN, in priority order:
  1. EX-slot match (ex_valid, ex_reg_write, ex_dest==src, not lw): use alu_out.
  2. MEM match (mem_wb_reg_write, mem_wb_dest==src): use mem_wb_data.
  3. Otherwise use the register file.
- Load-use: if the EX slot is a lw whose dest matches rs or rt, stall one cycle.
- hazard = stall condition. instr_ready = out_ready & ~hazard.
- On a hazard with out_ready=1, load a bubble into ID/EX.
- With out_ready=0, the ID/EX register and scoreboard hold their values, and instr_ready=0.

## Timing
- Latency: one cycle. The instruction accepted at edge N appears on ex_* after edge N.
- branch_taken and illegal are registered and assert in the same cycle as the corresponding ex_* contents.
- Reset values (synchronous, rst_n=0 at an edge):
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, branch_taken, illegal: 0
  - ex_in1, ex_in2, ex_store_data, branch_target: 0
  - ex_opcode, ex_funccode, ex_dest: 0
  - scoreboard: cleared
  - instr_ready: 0 during reset
- Reset mid-stall discards the held instruction.
- A branch is not stalled by a hazard on its own operands beyond the normal interlock.
- Fetch flushes the wrong-path instruction; this block does not.
- A bubble never produces branch_taken or illegal.

## Configuration
- OPERAND_FWD_EN defined: forwarding as described. The only stall is load-use, one cycle.
- OPERAND_FWD_EN undefined:
  - alu_out and the mem_wb_* inputs are ignored.
  - A 2-entry scoreboard shift register holds {valid, dest} for the EX and MEM slots. It shifts when out_ready=1, and a bubble enters on a stall.
  - Stall while rs or rt (nonzero) matches either entry. Worst case is two stall cycles.

## Structure
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_BEQ, OP_LW, OP_SW
  - funct constant FN_ADD
  - a struct for the decoded control bundle
- Sub-module hazard_unit holds forwarding-select and stall logic, plus the scoreboard when OPERAND_FWD_EN is undefined.
- The top level holds decode, sign-extension, beq compare and the ID/EX register.

## Test plan
- Reset, then add r3=r1+r2 with rs_data=5 and rt_data=7: the next cycle shows ex_in1=5, ex_in2=7, ex_opcode=0, ex_funccode=0x20, ex_dest=3, ex_reg_write=1.
- addi with imm=0xFFFC: ex_in2=0xFFFFFFFC. sw r4,8(r5): mem_write=1, reg_write=0, ex_store_data=r4.
- lw r2, then add r6=r2+r1 back-to-back:
  - FWD_EN: exactly one bubble, then the add issues with in1=mem_wb_data.
  - Without FWD_EN: two bubbles.
- add r1 followed by a dependent addi on r1, with FWD_EN and alu_out=0x1234: addi in1=0x1234, zero stalls.
- beq at pc=0x100 with imm=3 and equal operands: branch_taken=1, branch_target=0x110. With unequal operands: branch_taken=0.
- Opcode 0x3F: illegal pulse and a bubble. Writing r0: reg_write=0. rst_n low during a load-use stall: all outputs 0 on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and decode helpers for the operand_issue decode/issue stage.
//   OP_* / FN_ADD : opcode and funct encodings of the supported instructions
//   ctrl_t        : decoded control bundle for one instruction
//   decode_instr  : opcode/funct -> ctrl_t (legal=0 for unsupported encodings)
//   reg_match     : hazard/forwarding hit test that never matches r0
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  typedef struct packed {
    logic legal;
    logic use_rs;
    logic use_rt;     // rt is read as a source (not a destination)
    logic use_imm;    // in2 comes from the sign-extended immediate
    logic dest_rd;    // destination is rd rather than rt
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic is_beq;
  } ctrl_t;

  function automatic ctrl_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD) begin
          c.legal     = 1'b1;
          c.use_rs    = 1'b1;
          c.use_rt    = 1'b1;
          c.dest_rd   = 1'b1;
          c.reg_write = 1'b1;
        end
      end
      OP_ADDI, OP_LW: begin
        c.legal     = 1'b1;
        c.use_rs    = 1'b1;
        c.use_imm   = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read  = (opcode == OP_LW);
      end
      OP_SW: begin
        c.legal     = 1'b1;
        c.use_rs    = 1'b1;
        c.use_rt    = 1'b1;
        c.use_imm   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.legal  = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.is_beq = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic reg_match(input logic valid, input logic [4:0] dest,
                                     input logic [4:0] src);
    return valid && (src != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: operand source selection and RAW interlock for operand_issue.
// Build option OPERAND_FWD_EN:
//   defined   - forward from EX (alu_out) and MEM (mem_wb_*); stall only on load-use.
//   undefined - no forwarding; 2-entry {valid,dest} scoreboard of EX and MEM slots,
//               stall while any used nonzero source matches a live entry.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset (scoreboard only)
//   out_ready                  back end advances; scoreboard shifts only when high
//   rs, rt, use_rs, use_rt     decoded source registers and whether each is read
//   rs_data, rt_data           register-file read data
//   ex_valid/reg_write/mem_read/dest   current ID/EX slot contents
//   alu_out, mem_wb_*          forwarding sources
//   issue_we, issue_dest       write being loaded into ID/EX this cycle (0 for bubbles)
//   rs_val, rt_val             selected operand values
//   hazard                     interlock: the instruction must not issue this cycle
module hazard_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        out_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] alu_out,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_dest,
  input  logic [31:0] mem_wb_data,
  input  logic        issue_we,
  input  logic [4:0]  issue_dest,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic        hazard
);

`ifdef OPERAND_FWD_EN
  logic ex_fwd_ok;
  logic ex_load;
  // A load's data is not in alu_out yet, so an EX-slot lw is never a forwarding source.
  assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;
  assign ex_load   = ex_valid & ex_reg_write & ex_mem_read;

  always_comb begin
    rs_val = rs_data;
    if (rs == 5'd0)                                        rs_val = '0;
    else if (reg_match(ex_fwd_ok, ex_dest, rs))            rs_val = alu_out;
    else if (reg_match(mem_wb_reg_write, mem_wb_dest, rs)) rs_val = mem_wb_data;

    rt_val = rt_data;
    if (rt == 5'd0)                                        rt_val = '0;
    else if (reg_match(ex_fwd_ok, ex_dest, rt))            rt_val = alu_out;
    else if (reg_match(mem_wb_reg_write, mem_wb_dest, rt)) rt_val = mem_wb_data;
  end

  assign hazard = (use_rs & reg_match(ex_load, ex_dest, rs)) |
                  (use_rt & reg_match(ex_load, ex_dest, rt));

  logic unused_fwd;
  assign unused_fwd = ^{clk, rst_n, out_ready, issue_we, issue_dest};
`else
  // Entry 0 mirrors the EX slot, entry 1 the MEM slot; WB is covered by the
  // write-before-read register file.
  logic [1:0] sb_valid;
  logic [4:0] sb_dest0;
  logic [4:0] sb_dest1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid <= '0;
      sb_dest0 <= '0;
      sb_dest1 <= '0;
    end else if (out_ready) begin
      sb_valid <= {sb_valid[0], issue_we};
      sb_dest1 <= sb_dest0;
      sb_dest0 <= issue_dest;
    end
  end

  always_comb begin
    rs_val = (rs == 5'd0) ? '0 : rs_data;
    rt_val = (rt == 5'd0) ? '0 : rt_data;
  end

  assign hazard =
    (use_rs & (reg_match(sb_valid[0], sb_dest0, rs) | reg_match(sb_valid[1], sb_dest1, rs))) |
    (use_rt & (reg_match(sb_valid[0], sb_dest0, rt) | reg_match(sb_valid[1], sb_dest1, rt)));

  logic unused_nofwd;
  assign unused_nofwd = ^{alu_out, mem_wb_reg_write, mem_wb_dest, mem_wb_data,
                          ex_valid, ex_reg_write, ex_mem_read, ex_dest};
`endif

endmodule

// File: rtl/operand_issue.sv
// operand_issue: MIPS decode/issue stage owning the ID/EX register.
// Splits the instruction, reads the register file, sign-extends immediates, resolves beq
// and loads in1/in2/opcode/funccode plus control into ID/EX with one cycle of latency.
// Build option OPERAND_FWD_EN selects forwarding vs. scoreboard interlock (see hazard_unit).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   instr_valid/instr_ready         fetch handshake; instr/pc are the word and its address
//   rs_addr, rt_addr / rs_data, rt_data   register-file read port (same cycle)
//   alu_out, mem_wb_*               forwarding sources
//   out_ready                       back end advances; low freezes ID/EX
//   ex_*                            registered ID/EX contents for the ALU and later stages
//   branch_taken, branch_target     one-cycle redirect pulse for a taken beq
//   illegal                         one-cycle pulse when an unsupported encoding is accepted
module operand_issue
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_out,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_dest,
  input  logic [31:0] mem_wb_data,
  input  logic        out_ready,
  output logic        ex_valid,
  output logic [31:0] ex_in1,
  output logic [31:0] ex_in2,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funccode,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  ctrl_t       ctrl;

  assign opcode   = instr[31:26];
  assign rs_addr  = instr[25:21];
  assign rt_addr  = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign ctrl     = decode_instr(opcode, funct);

  // Writes to r0 are dropped here so no later stage ever sees dest=0 with reg_write=1.
  logic [4:0] dest_raw;
  logic       wr_en;
  logic [4:0] wr_dest;
  assign dest_raw = ctrl.dest_rd ? rd : rt_addr;
  assign wr_en    = ctrl.reg_write & (dest_raw != 5'd0);
  assign wr_dest  = wr_en ? dest_raw : 5'd0;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hazard;
  logic        accept;
  logic        issue;
  logic        take;

  assign instr_ready = rst_n & out_ready & ~hazard;
  assign accept      = instr_valid & instr_ready;
  assign issue       = accept & ctrl.legal;
  assign take        = issue & ctrl.is_beq & (rs_val == rt_val);

  hazard_unit u_hazard (
    .clk              (clk),
    .rst_n            (rst_n),
    .out_ready        (out_ready),
    .rs               (rs_addr),
    .rt               (rt_addr),
    .use_rs           (ctrl.use_rs),
    .use_rt           (ctrl.use_rt),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .ex_valid         (ex_valid),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_dest          (ex_dest),
    .alu_out          (alu_out),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_dest      (mem_wb_dest),
    .mem_wb_data      (mem_wb_data),
    .issue_we         (issue & wr_en),
    .issue_dest       (wr_dest),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .hazard           (hazard)
  );

  // Anything other than an issuing instruction (stall, idle, illegal) loads an all-zero bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_in1        <= '0;
      ex_in2        <= '0;
      ex_opcode     <= '0;
      ex_funccode   <= '0;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_store_data <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      illegal       <= 1'b0;
    end else if (out_ready) begin
      ex_valid      <= issue;
      ex_in1        <= issue ? rs_val : '0;
      ex_in2        <= issue ? (ctrl.use_imm ? imm_sext : rt_val) : '0;
      ex_opcode     <= issue ? opcode : '0;
      ex_funccode   <= (issue && opcode == OP_RTYPE) ? funct : '0;
      ex_dest       <= issue ? wr_dest : '0;
      ex_reg_write  <= issue & wr_en;
      ex_mem_read   <= issue & ctrl.mem_read;
      ex_mem_write  <= issue & ctrl.mem_write;
      ex_store_data <= (issue && ctrl.mem_write) ? rt_val : '0;
      branch_taken  <= take;
      branch_target <= take ? (pc + 32'd4 + {imm_sext[29:0], 2'b00}) : '0;
      illegal       <= accept & ~ctrl.legal;
    end else begin
      // Frozen: ID/EX holds, but redirect/illegal must not repeat.
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed test-plan cases plus randomized traffic, all checked against
// a behavioural model of the issue stage (expected ID/EX contents and pending writers).
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_out;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_data;
  logic        out_ready;
  logic        ex_valid;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funccode;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_store_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;

  operand_issue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .pc               (pc),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .alu_out          (alu_out),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_dest      (mem_wb_dest),
    .mem_wb_data      (mem_wb_data),
    .out_ready        (out_ready),
    .ex_valid         (ex_valid),
    .ex_in1           (ex_in1),
    .ex_in2           (ex_in2),
    .ex_opcode        (ex_opcode),
    .ex_funccode      (ex_funccode),
    .ex_dest          (ex_dest),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_store_data    (ex_store_data),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .illegal          (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected ID/EX contents.
  typedef struct packed {
    logic        valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        bt;
    logic [31:0] btgt;
    logic        ill;
  } ex_t;

  ex_t        m = '0;
  bit         pend_v[2];     // register writes issued 1 and 2 cycles of advance ago
  logic [4:0] pend_d[2];
  bit         obs_ready;

  function automatic logic [31:0] r_add(input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
`ifdef OPERAND_FWD_EN
    if (m.valid && m.rw && !m.mr && m.dest == r) return alu_out;
    if (mem_wb_reg_write && mem_wb_dest == r) return mem_wb_data;
`endif
    return rf;
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef OPERAND_FWD_EN
    return m.valid && m.mr && m.rw && m.dest == r;
`else
    return (pend_v[0] && pend_d[0] == r) || (pend_v[1] && pend_d[1] == r);
`endif
  endfunction

  task automatic check_ex();
    check("ex_valid",      32'(ex_valid),      32'(m.valid));
    check("ex_in1",        ex_in1,             m.in1);
    check("ex_in2",        ex_in2,             m.in2);
    check("ex_opcode",     32'(ex_opcode),     32'(m.op));
    check("ex_funccode",   32'(ex_funccode),   32'(m.fn));
    check("ex_dest",       32'(ex_dest),       32'(m.dest));
    check("ex_reg_write",  32'(ex_reg_write),  32'(m.rw));
    check("ex_mem_read",   32'(ex_mem_read),   32'(m.mr));
    check("ex_mem_write",  32'(ex_mem_write),  32'(m.mw));
    check("ex_store_data", ex_store_data,      m.sd);
    check("branch_taken",  32'(branch_taken),  32'(m.bt));
    check("branch_target", branch_target,      m.btgt);
    check("illegal",       32'(illegal),       32'(m.ill));
  endtask

  // One cycle: inputs already driven just after a rising edge.
  task automatic step();
    logic [5:0]  op;
    logic [4:0]  rs, rt, dst;
    logic [31:0] sx, a, b;
    bit legal, use_rs, use_rt, use_imm, rw, mr, mw, beq, hz, rdy, acc, rwe;
    ex_t nm;
    op = instr[31:26];
    rs = instr[25:21];
    rt = instr[20:16];
    sx = {{16{instr[15]}}, instr[15:0]};
    legal = 1; use_rs = 1; use_rt = 0; use_imm = 1; rw = 0; mr = 0; mw = 0; beq = 0;
    dst = rt;
    case (op)
      6'h00: begin
        legal = (instr[5:0] == 6'h20); use_rt = 1; use_imm = 0; rw = 1; dst = instr[15:11];
      end
      6'h08: rw = 1;
      6'h23: begin rw = 1; mr = 1; end
      6'h2B: begin use_rt = 1; mw = 1; end
      6'h04: begin use_rt = 1; use_imm = 0; beq = 1; end
      default: legal = 0;
    endcase
    if (!legal) begin use_rs = 0; use_rt = 0; end
    hz  = (use_rs && blocked(rs)) || (use_rt && blocked(rt));
    rdy = rst_n && out_ready && !hz;
    a   = operand(rs, rs_data);
    b   = operand(rt, rt_data);
    #3;
    check("rs_addr", 32'(rs_addr), 32'(rs));
    check("rt_addr", 32'(rt_addr), 32'(rt));
    check("instr_ready", 32'(instr_ready), 32'(rdy));
    obs_ready = instr_ready;
    rwe = 0;
    if (!rst_n) begin
      nm = '0;
      pend_v[0] = 0; pend_v[1] = 0;
    end else if (out_ready) begin
      acc = instr_valid && rdy;
      nm  = '0;
      if (acc && legal) begin
        rwe      = rw && dst != 5'd0;
        nm.valid = 1;
        nm.in1   = a;
        nm.in2   = use_imm ? sx : b;
        nm.op    = op;
        nm.fn    = (op == 6'h00) ? instr[5:0] : 6'h00;
        nm.rw    = rwe;
        nm.dest  = rwe ? dst : 5'd0;
        nm.mr    = mr;
        nm.mw    = mw;
        nm.sd    = mw ? b : 32'd0;
        if (beq && a == b) begin
          nm.bt   = 1;
          nm.btgt = pc + 32'd4 + (sx << 2);
        end
      end
      nm.ill    = acc && !legal;
      pend_v[1] = pend_v[0];
      pend_d[1] = pend_d[0];
      pend_v[0] = acc && legal && rwe;
      pend_d[0] = dst;
    end else begin
      nm     = m;
      nm.bt  = 0;
      nm.ill = 0;
    end
    @(posedge clk);
    #1;
    m = nm;
    check_ex();
  endtask

  task automatic issue(input logic [31:0] ins, output int stalls);
    instr = ins;
    instr_valid = 1;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_ready) break;
      stalls++;
    end
    instr_valid = 0;
    if (!obs_ready) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    instr_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  int stalls;

  initial begin
    rst_n = 0; instr_valid = 0; instr = '0; pc = '0; rs_data = '0; rt_data = '0;
    alu_out = '0; mem_wb_reg_write = 0; mem_wb_dest = '0; mem_wb_data = '0; out_ready = 1;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1;

    // add r3 = r1 + r2
    rs_data = 5; rt_data = 7;
    issue(r_add(3, 1, 2), stalls);
    check("add_in1", ex_in1, 32'd5);
    check("add_in2", ex_in2, 32'd7);
    check("add_fn", 32'(ex_funccode), 32'h20);
    check("add_dest", 32'(ex_dest), 32'd3);
    idle(2);

    // addi r4 = r5 + sext(0xFFFC)
    rs_data = 32'h10;
    issue(i_op(6'h08, 5, 4, 16'hFFFC), stalls);
    check("addi_in2", ex_in2, 32'hFFFF_FFFC);
    idle(2);

    // sw r4, 8(r5)
    rs_data = 32'h200; rt_data = 32'hDEAD;
    issue(i_op(6'h2B, 5, 4, 16'd8), stalls);
    check("sw_mw", 32'(ex_mem_write), 32'd1);
    check("sw_rw", 32'(ex_reg_write), 32'd0);
    check("sw_sd", ex_store_data, 32'hDEAD);
    idle(2);

    // lw r2 then dependent add r6 = r2 + r1
    issue(i_op(6'h23, 7, 2, 16'd0), stalls);
    mem_wb_reg_write = 1; mem_wb_dest = 2; mem_wb_data = 32'hCAFE; rs_data = 32'h55;
    issue(r_add(6, 2, 1), stalls);
`ifdef OPERAND_FWD_EN
    check("lu_stalls", 32'(stalls), 32'd1);
    check("lu_in1", ex_in1, 32'hCAFE);
`else
    check("lu_stalls", 32'(stalls), 32'd2);
    check("lu_in1", ex_in1, 32'h55);
`endif
    mem_wb_reg_write = 0;
    idle(2);

    // add r1 then dependent addi r8 = r1 + 5
    issue(r_add(1, 2, 3), stalls);
    alu_out = 32'h1234; rs_data = 32'h77;
    issue(i_op(6'h08, 1, 8, 16'd5), stalls);
`ifdef OPERAND_FWD_EN
    check("dep_stalls", 32'(stalls), 32'd0);
    check("dep_in1", ex_in1, 32'h1234);
`else
    check("dep_stalls", 32'(stalls), 32'd2);
    check("dep_in1", ex_in1, 32'h77);
`endif
    alu_out = '0;
    idle(2);

    // beq taken / not taken
    pc = 32'h100; rs_data = 9; rt_data = 9;
    issue(i_op(6'h04, 9, 10, 16'd3), stalls);
    check("beq_taken", 32'(branch_taken), 32'd1);
    check("beq_target", branch_target, 32'h110);
    rt_data = 10;
    issue(i_op(6'h04, 9, 10, 16'd3), stalls);
    check("beq_not_taken", 32'(branch_taken), 32'd0);
    idle(1);
    check("beq_pulse_end", 32'(branch_taken), 32'd0);

    // illegal opcode
    issue({6'h3F, 26'h0}, stalls);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_bubble", 32'(ex_valid), 32'd0);
    idle(1);

    // write to r0
    issue(i_op(6'h08, 1, 0, 16'd5), stalls);
    check("r0_rw", 32'(ex_reg_write), 32'd0);
    idle(2);

    // reset during a load-use stall
    issue(i_op(6'h23, 7, 2, 16'd0), stalls);
    instr = r_add(6, 2, 1); instr_valid = 1;
    step();
    check("stall_seen", 32'(obs_ready), 32'd0);
    rst_n = 0;
    step();
    check("rst_stall_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_mr", 32'(ex_mem_read), 32'd0);
    rst_n = 1; instr_valid = 0;
    step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int k;
      rst_n       = ($urandom % 150) != 0;
      out_ready   = ($urandom % 5) != 0;
      instr_valid = ($urandom % 6) != 0;
      k = $urandom % 8;
      case (k)
        0, 1: instr = r_add($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        2:    instr = {6'h00, 20'($urandom), 6'h22};
        3:    instr = i_op(6'h08, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        4:    instr = i_op(6'h23, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        5:    instr = i_op(6'h2B, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        6:    instr = i_op(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        default: instr = {(($urandom % 2) != 0) ? 6'h3F : 6'h02, 26'($urandom)};
      endcase
      pc               = {$urandom} & 32'hFFFF_FFFC;
      rs_data          = $urandom;
      rt_data          = (($urandom % 2) != 0) ? rs_data : $urandom;
      alu_out          = $urandom;
      mem_wb_reg_write = ($urandom % 2) != 0;
      mem_wb_dest      = 5'($urandom_range(0, 3));
      mem_wb_data      = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
